// File: rtl/uart_rx_frame.sv
// uart_rx_frame
// Receives one UART character: a start bit, 8 data bits (LSB first), one
// parity bit and one stop bit. The character is returned as a 9-bit frame,
// {parity bit as received, data[7:0]}, together with a one-cycle strobe.
//
// Ports
//   clk         : system clock; all logic runs on its rising edge
//   rst         : synchronous, active-high reset
//   rx          : asynchronous serial input, idles high
//   frame       : {parity, data}; holds the last delivered character
//   frame_valid : one-cycle strobe; frame and parity_err are valid with it
//   parity_err  : parity mismatch for the current frame; held until the next delivery
//   framing_err : one-cycle strobe when the stop bit is sampled low
//   busy        : high whenever the receiver is not idle
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [8:0] frame,
  output logic       frame_valid,
  output logic       parity_err,
  output logic       framing_err,
  output logic       busy
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic            PAR_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic             r_sync1;
  logic             r_rxs;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             r_par_bit;

  logic [8:0]       r_frame;
  logic             r_frame_valid;
  logic             r_parity_err;
  logic             r_framing_err;

  logic             w_bit_end;
  logic             w_half;
  logic             w_deliver;
  logic             w_stop_bad;
  logic             w_parity_calc;

  assign w_bit_end     = (r_cnt == CNT_LAST);
  assign w_half        = (r_cnt == CNT_HALF);
  assign w_parity_calc = (^r_shift) ^ PAR_ODD;

  // Two-flop synchroniser; both stages reset to the idle level so a reset
  // never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_deliver    = 1'b0;
    w_stop_bad   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rxs) w_state_next = S_START;
      end
      S_START: begin
        // Re-check the line at mid start bit to reject short glitches.
        if (w_half) w_state_next = r_rxs ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_bit_end && (r_idx == 3'd7)) w_state_next = S_PARITY;
      end
      S_PARITY: begin
        if (w_bit_end) w_state_next = S_STOP;
      end
      S_STOP: begin
        // Leaving at mid stop bit gives half a bit of margin before the
        // next start edge of a back-to-back character.
        if (w_bit_end) begin
          if (r_rxs) begin
            w_state_next = S_IDLE;
            w_deliver    = 1'b1;
          end else begin
            w_state_next = S_WAIT_IDLE;
            w_stop_bad   = 1'b1;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (r_rxs) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Bit timing: the counter restarts on every state change and at the end of
  // every bit period. Since START exits at mid-bit, each later full period
  // ends at the middle of the next bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_idx     <= 3'd0;
      r_shift   <= 8'h00;
      r_par_bit <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) || (w_state_next != r_state) || w_bit_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if ((r_state == S_START) && (w_state_next == S_DATA)) begin
        r_idx <= 3'd0;
      end

      if ((r_state == S_DATA) && w_bit_end) begin
        r_shift[r_idx] <= r_rxs;
        r_idx          <= r_idx + 3'd1;
      end

      if ((r_state == S_PARITY) && w_bit_end) begin
        r_par_bit <= r_rxs;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame       <= 9'h000;
      r_frame_valid <= 1'b0;
      r_parity_err  <= 1'b0;
      r_framing_err <= 1'b0;
    end else begin
      r_frame_valid <= w_deliver;
      r_framing_err <= w_stop_bad;
      if (w_deliver) begin
        r_frame      <= {r_par_bit, r_shift};
        r_parity_err <= (r_par_bit != w_parity_calc);
      end
    end
  end

  assign frame       = r_frame;
  assign frame_valid = r_frame_valid;
  assign parity_err  = r_parity_err;
  assign framing_err = r_framing_err;
  assign busy        = (r_state != S_IDLE);

endmodule
